// File: rtl/sreg_seq_ctrl_pkg.sv
// Shared types and constants for the Sreg sequencer: FSM states, command modes
// and the Sreg control-pin settings used in each mode.
package sreg_seq_ctrl_pkg;

  localparam int unsigned SR_WIDTH    = 4;
  localparam int unsigned SR_SOUT_LAT = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SHIFT  = 3'd1,
    S_SAMPLE = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic MODE_SIPO = 1'b0;
  localparam logic MODE_SISO = 1'b1;

  typedef struct packed {
    logic choice;
    logic resetsi;
    logic resetpo;
  } sr_ctrl_t;

  localparam sr_ctrl_t CTRL_IDLE = '{choice: 1'b0, resetsi: 1'b1, resetpo: 1'b1};
  localparam sr_ctrl_t CTRL_SIPO = '{choice: 1'b0, resetsi: 1'b0, resetpo: 1'b1};
  localparam sr_ctrl_t CTRL_SISO = '{choice: 1'b1, resetsi: 1'b1, resetpo: 1'b0};

  function automatic sr_ctrl_t ctrl_for_mode(input logic mode);
    return (mode == MODE_SISO) ? CTRL_SISO : CTRL_SIPO;
  endfunction

endpackage

// File: rtl/sreg_rx_capture.sv
// Receive shift register for the Sreg serial output, with synchronous clear,
// shift enable and a compare of the post-edge value against a reference word.
module sreg_rx_capture #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] ref_i,
  output logic [WIDTH-1:0] rx_nxt_c,
  output logic             match_c
);

  logic [WIDTH-1:0] rx_q, rx_d;

  always_comb begin
    rx_d = rx_q;
    if (clr_i) begin
      rx_d = '0;
    end else if (en_i) begin
      rx_d = {rx_q[WIDTH-2:0], bit_i};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_q <= '0;
    end else begin
      rx_q <= rx_d;
    end
  end

  // The FSM latches the result on the same edge as the final shift, so it needs the next value.
  assign rx_nxt_c = rx_d;
  assign match_c  = (rx_d == ref_i);

endmodule

// File: rtl/sreg_seq_ctrl.sv
// Sequencer for the 4-bit Sreg: takes one command word, shifts it into Sreg MSB first,
// and returns either the parallel (SIPO) or the looped-back serial (SISO) result.
module sreg_seq_ctrl
  import sreg_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH    = SR_WIDTH,
  parameter int unsigned SOUT_LAT = SR_SOUT_LAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mode,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  output logic             sr_sinp,
  output logic             sr_choice,
  output logic             sr_resetsi,
  output logic             sr_resetpo,
  input  logic [WIDTH-1:0] sr_pout,
  input  logic             sr_sout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_match,
  output logic             busy
);

  localparam int unsigned      CNT_W        = $clog2(WIDTH + SOUT_LAT + 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(SOUT_LAT - 1);
  localparam logic [CNT_W-1:0] DRAIN_K_BASE = CNT_W'(WIDTH + 1);
  localparam logic [CNT_W-1:0] CAP_LO       = CNT_W'(SOUT_LAT);
  localparam logic [CNT_W-1:0] CAP_HI       = CNT_W'(SOUT_LAT + WIDTH);
  localparam logic [WIDTH-1:0] MSB_MASK     = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] data_q, data_d;
  sr_ctrl_t         ctrl_q, ctrl_d;
  logic             sinp_q, sinp_d;
  logic             cmd_ready_q;
  logic             busy_q;
  logic             res_valid_q;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_match_q, res_match_d;

  logic [CNT_W-1:0] k_c;
  logic             cap_en_c;
  logic             cap_clr_c;
  logic [WIDTH-1:0] rx_nxt_c;
  logic             rx_match_c;

  // Next-state, counter and result latching.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    data_d      = data_q;
    res_data_d  = res_data_q;
    res_match_d = res_match_q;
    cap_clr_c   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d   = S_SHIFT;
          mode_d    = cmd_mode;
          data_d    = cmd_data;
          cap_clr_c = 1'b1;
        end
      end
      S_SHIFT: begin
        if (cnt_q == SHIFT_LAST) begin
          state_d = (mode_q == MODE_SISO) ? S_DRAIN : S_SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SAMPLE: begin
        state_d     = S_DONE;
        res_data_d  = sr_pout;
        res_match_d = 1'b0;
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d     = S_DONE;
          res_data_d  = rx_nxt_c;
          res_match_d = rx_match_c;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort drops the in-flight command without touching the previous result.
    if (abort && (state_q inside {S_SHIFT, S_SAMPLE, S_DRAIN})) begin
      state_d     = S_IDLE;
      res_data_d  = res_data_q;
      res_match_d = res_match_q;
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // Sreg pin values for the coming cycle, so the pins themselves can be registered.
  always_comb begin
    ctrl_d = CTRL_IDLE;
    if (state_d inside {S_SHIFT, S_SAMPLE, S_DRAIN}) begin
      ctrl_d = ctrl_for_mode(mode_d);
    end
    sinp_d = (state_d == S_SHIFT) && (|(data_d & (MSB_MASK >> cnt_d)));
  end

  // k counts cycles since SHIFT entry; the serial output is captured once the pipeline has filled.
  always_comb begin
    k_c = '0;
    if (state_q == S_SHIFT) begin
      k_c = cnt_q + CNT_W'(1);
    end else if (state_q == S_DRAIN) begin
      k_c = cnt_q + DRAIN_K_BASE;
    end
    cap_en_c = (k_c > CAP_LO) && (k_c <= CAP_HI);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mode_q      <= MODE_SIPO;
      data_q      <= '0;
      ctrl_q      <= CTRL_IDLE;
      sinp_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_match_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      data_q      <= data_d;
      ctrl_q      <= ctrl_d;
      sinp_q      <= sinp_d;
      cmd_ready_q <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
      res_valid_q <= (state_d == S_DONE);
      res_data_q  <= res_data_d;
      res_match_q <= res_match_d;
    end
  end

  sreg_rx_capture #(
    .WIDTH (WIDTH)
  ) u_rx_capture (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (cap_clr_c),
    .en_i     (cap_en_c),
    .bit_i    (sr_sout),
    .ref_i    (data_q),
    .rx_nxt_c (rx_nxt_c),
    .match_c  (rx_match_c)
  );

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign sr_sinp    = sinp_q;
  assign sr_choice  = ctrl_q.choice;
  assign sr_resetsi = ctrl_q.resetsi;
  assign sr_resetpo = ctrl_q.resetpo;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_match  = res_match_q;

endmodule

// File: tb/tb_sreg_seq_ctrl.sv
// Bench for sreg_seq_ctrl: drives directed and random commands into the sequencer
// connected to a behavioural Sreg, and checks every cycle against a timeline model.
module tb_sreg_seq_ctrl;

  localparam int unsigned W        = 4;
  localparam int unsigned SOUT_LAT = 4;
  localparam int          LAT_SIPO = W + 2;
  localparam int          LAT_SISO = W + SOUT_LAT + 1;

  logic         clk       = 1'b0;
  logic         reset     = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_mode  = 1'b0;
  logic [W-1:0] cmd_data  = '0;
  logic         abort     = 1'b0;
  logic         res_ready = 1'b0;
  logic         cmd_ready, sr_sinp, sr_choice, sr_resetsi, sr_resetpo, sr_sout;
  logic         res_valid, res_match, busy;
  logic [W-1:0] sr_pout, res_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sreg_seq_ctrl #(
    .WIDTH    (W),
    .SOUT_LAT (SOUT_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_data   (cmd_data),
    .abort      (abort),
    .sr_sinp    (sr_sinp),
    .sr_choice  (sr_choice),
    .sr_resetsi (sr_resetsi),
    .sr_resetpo (sr_resetpo),
    .sr_pout    (sr_pout),
    .sr_sout    (sr_sout),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_match  (res_match),
    .busy       (busy)
  );

  // Behavioural Sreg: a SIPO chain and a SISO chain of W stages each.
  logic [W-1:0] si_q = '0;
  logic [W-1:0] po_q = '0;
  always @(posedge clk) begin
    if (sr_resetsi) si_q <= '0;
    else if (!sr_choice) si_q <= {si_q[W-2:0], sr_sinp};
    if (sr_resetpo) po_q <= '0;
    else if (sr_choice) po_q <= {po_q[W-2:0], sr_sinp};
  end
  assign sr_pout = si_q;
  assign sr_sout = po_q[W-1];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat_of(input logic m);
    return m ? LAT_SISO : LAT_SIPO;
  endfunction

  task automatic check_reset_vals(input string tag);
    check_eq({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    check_eq({tag, ".resetsi"},   32'(sr_resetsi), 32'd1);
    check_eq({tag, ".resetpo"},   32'(sr_resetpo), 32'd1);
    check_eq({tag, ".choice"},    32'(sr_choice), 32'd0);
    check_eq({tag, ".sinp"},      32'(sr_sinp), 32'd0);
    check_eq({tag, ".res_valid"}, 32'(res_valid), 32'd0);
    check_eq({tag, ".res_data"},  32'(res_data), 32'd0);
    check_eq({tag, ".res_match"}, 32'(res_match), 32'd0);
    check_eq({tag, ".busy"},      32'(busy), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    check_eq({tag, ".busy"},      32'(busy), 32'd0);
    check_eq({tag, ".res_valid"}, 32'(res_valid), 32'd0);
    check_eq({tag, ".ctrl"},      32'({sr_choice, sr_resetsi, sr_resetpo}), 32'(3'b011));
    check_eq({tag, ".sinp"},      32'(sr_sinp), 32'd0);
  endtask

  task automatic start_cmd(input logic m, input logic [W-1:0] d);
    check_eq("ready_pre", 32'(cmd_ready), 32'd1);
    abort     = 1'b0;
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Walks one command from the first cycle after acceptance to DONE (or to an abort).
  task automatic follow_cmd(input logic m, input logic [W-1:0] d, input int abort_at,
                            input int hold, output bit done);
    int           lat;
    logic [W-1:0] sh;
    lat  = lat_of(m);
    done = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      sh = d << (c - 1);
      check_eq("busy",      32'(busy), 32'd1);
      check_eq("cmd_ready", 32'(cmd_ready), 32'd0);
      check_eq("res_valid", 32'(res_valid), 32'(c == lat));
      check_eq("sinp",      32'(sr_sinp), (c <= int'(W)) ? 32'(sh[W-1]) : 32'd0);
      if (c < lat)
        check_eq("ctrl", 32'({sr_choice, sr_resetsi, sr_resetpo}), m ? 32'(3'b110) : 32'(3'b001));
      else
        check_eq("ctrl_done", 32'({sr_choice, sr_resetsi, sr_resetpo}), 32'(3'b011));
      if (c == abort_at) begin
        cmd_valid = 1'b0;
        abort     = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort");
        for (int i = 0; i < 3; i++) begin
          tick();
          check_eq("abort.no_result", 32'(res_valid), 32'd0);
        end
        return;
      end
      if (c < lat) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_mode  = 1'($urandom_range(0, 1));
        cmd_data  = W'($urandom);
        tick();
      end
    end
    check_eq("res_data",  32'(res_data), 32'(d));
    check_eq("res_match", 32'(res_match), 32'(m));
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_data  = W'($urandom);
      abort     = 1'($urandom_range(0, 1));
      tick();
      check_eq("hold.res_valid", 32'(res_valid), 32'd1);
      check_eq("hold.res_data",  32'(res_data), 32'(d));
      check_eq("hold.res_match", 32'(res_match), 32'(m));
      check_eq("hold.cmd_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;
    done      = 1'b1;
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    cmd_valid = 1'b0;
    tick();
    res_ready = 1'b0;
    check_idle("release");
  endtask

  // Result accepted and next command presented on the same cycle.
  task automatic b2b(input logic m, input logic [W-1:0] d);
    res_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_data  = d;
    tick();
    res_ready = 1'b0;
    check_idle("b2b.gap");
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    bit           done;
    logic         m, nm;
    logic [W-1:0] d, nd;
    int           ab;

    #12;
    check_reset_vals("por");
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    check_idle("post_por");

    // SIPO 1011
    start_cmd(1'b0, 4'b1011);
    follow_cmd(1'b0, 4'b1011, 0, 0, done);
    release_result();

    // SISO 1111 then 0110
    start_cmd(1'b1, 4'b1111);
    follow_cmd(1'b1, 4'b1111, 0, 0, done);
    release_result();
    start_cmd(1'b1, 4'b0110);
    follow_cmd(1'b1, 4'b0110, 0, 0, done);
    release_result();

    // Result held for five cycles with cmd_valid/abort noise
    start_cmd(1'b0, 4'b1001);
    follow_cmd(1'b0, 4'b1001, 0, 5, done);
    release_result();

    // Abort on the second SHIFT cycle, then a clean command
    start_cmd(1'b1, 4'b1010);
    follow_cmd(1'b1, 4'b1010, 2, 0, done);
    check_eq("abort.done_flag", 32'(done), 32'd0);
    start_cmd(1'b0, 4'b0111);
    follow_cmd(1'b0, 4'b0111, 0, 0, done);

    // Back-to-back: SIPO 0111 handed off straight into SISO 1001
    b2b(1'b1, 4'b1001);
    follow_cmd(1'b1, 4'b1001, 0, 1, done);
    release_result();

    // Asynchronous reset in the middle of DRAIN
    start_cmd(1'b1, 4'b1101);
    repeat (5) tick();
    #3 reset = 1'b1;
    #1;
    check_reset_vals("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    check_idle("post_rst");
    check_eq("post_rst.res_data", 32'(res_data), 32'd0);

    // Random traffic
    m = 1'($urandom_range(0, 1));
    d = W'($urandom);
    start_cmd(m, d);
    for (int i = 0; i < 40; i++) begin
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 32'(lat_of(m) - 1))) : 0;
      follow_cmd(m, d, ab, int'($urandom_range(0, 3)), done);
      nm = 1'($urandom_range(0, 1));
      nd = W'($urandom);
      if (done && $urandom_range(0, 1) == 1) begin
        b2b(nm, nd);
      end else begin
        if (done) release_result();
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
          abort = 1'($urandom_range(0, 1));
          tick();
          abort = 1'b0;
          check_idle("gap");
        end
        start_cmd(nm, nd);
      end
      m = nm;
      d = nd;
    end
    follow_cmd(m, d, 0, 0, done);
    release_result();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
